// File: rtl/sbox_share_sched.sv
// sbox_share_sched: round-robin issue scheduler for the shared masked S-box.
// A tag pipeline tracks each issued byte and routes its result to the owner.
module sbox_share_sched #(
  parameter int d      = 2,
  parameter int LAT    = 6,
  parameter int R0_DLY = 0,
  parameter int R1_DLY = 2,
  parameter int R2_DLY = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic           req0_inv,
  input  logic [8*d-1:0] req0_data,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic           req1_inv,
  input  logic [8*d-1:0] req1_data,
  input  logic           rnd_valid,
  output logic           rnd_use_0,
  output logic           rnd_use_1,
  output logic           rnd_use_2,
  output logic [8*d-1:0] sb_in,
  output logic           sb_inverse_in,
  output logic           sb_inverse_out,
  input  logic [8*d-1:0] sb_out,
  output logic           rsp0_valid,
  output logic           rsp1_valid,
  output logic [8*d-1:0] rsp_data,
  output logic           rsp_inv,
  output logic           busy
);

  logic         r_prio;
  logic [LAT:1] r_tv;
  logic [LAT:1] r_own;
  logic [LAT:1] r_inv;
  logic [LAT:0] w_tv;
  logic         w_issue;
  logic         w_g0;
  logic         w_g1;

  // ready is gated by rst_n so nothing is granted while reset is held
  assign w_issue = rst_n & rnd_valid & ~flush
                 & (req0_valid | req1_valid);

  always_comb begin
    w_g0 = 1'b0;
    w_g1 = 1'b0;
    if (w_issue) begin
      unique case (1'b1)
        req0_valid & ~req1_valid: w_g0 = 1'b1;
        ~req0_valid & req1_valid: w_g1 = 1'b1;
        default: begin
          w_g0 = ~r_prio;
          w_g1 = r_prio;
        end
      endcase
    end
  end

  assign req0_ready    = w_g0;
  assign req1_ready    = w_g1;
  assign sb_in         = w_g0 ? req0_data :
                         w_g1 ? req1_data : '0;
  assign sb_inverse_in = (w_g0 & req0_inv)
                       | (w_g1 & req1_inv);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
      r_tv   <= '0;
      r_own  <= '0;
      r_inv  <= '0;
    end else begin
      r_own[1] <= w_g1;
      r_inv[1] <= sb_inverse_in;
      for (int i = 2; i <= LAT; i++) begin
        r_own[i] <= r_own[i-1];
        r_inv[i] <= r_inv[i-1];
      end
      if (flush) begin
        r_tv   <= '0;
        r_prio <= 1'b0;
      end else begin
        r_tv[1] <= w_issue;
        for (int i = 2; i <= LAT; i++) begin
          r_tv[i] <= r_tv[i-1];
        end
        if (w_g0) begin
          r_prio <= 1'b1;
        end else if (w_g1) begin
          r_prio <= 1'b0;
        end
      end
    end
  end

  // index 0 is the issue itself, index k is stage k
  assign w_tv = {r_tv, w_issue};

  assign rnd_use_0 = w_tv[R0_DLY];
  assign rnd_use_1 = w_tv[R1_DLY];
  assign rnd_use_2 = w_tv[R2_DLY];

  assign rsp0_valid     = r_tv[LAT] & ~r_own[LAT];
  assign rsp1_valid     = r_tv[LAT] & r_own[LAT];
  assign rsp_inv        = r_tv[LAT] & r_inv[LAT];
  assign sb_inverse_out = r_tv[LAT] & r_inv[LAT];
  assign rsp_data       = sb_out;
  assign busy           = |r_tv;

endmodule

// File: doc/sbox_share_sched.md
# sbox_share_sched

Issue scheduler and arbiter for the shared masked S-box pipeline (fixed latency, no stall input, randomness consumed at fixed stages). Two requesters (0 = state datapath, 1 = key schedule) each present one masked byte plus an inverse flag; the block grants one request per cycle when fresh randomness is available. It drives the S-box input sharing and `inverse_in`, and tracks every issued byte through a tag pipeline. It then drives `inverse_out` and routes each result back to its owner exactly LAT cycles later.

## Interface
- d, 2, number of shares per bit
- LAT, 6, S-box pipeline latency in cycles
- R0_DLY, 0, cycles from issue to consumption of rnd_0
- R1_DLY, 2, cycles from issue to consumption of rnd_1
- R2_DLY, 4, cycles from issue to consumption of rnd_2 (all R*_DLY < LAT)

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of all in-flight tags
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  grant; a transfer occurs on valid & ready
- req0_inv / req1_inv  in  1  1 = inverse S-box for this byte
- req0_data / req1_data  in  8*d  masked byte; bit b shares at [b*d +: d]
- rnd_valid  in  1  randomness for a new issue is available this cycle
- rnd_use_0 / rnd_use_1 / rnd_use_2  out  1  PRNG advance strobes for rnd_0/1/2 buses
- sb_in  out  8*d  to S-box i0..i7, same bit packing
- sb_inverse_in  out  1  to S-box inverse_in
- sb_inverse_out  out  1  to S-box inverse_out
- sb_out  in  8*d  from S-box o0..o7
- rsp0_valid / rsp1_valid  out  1  result for requester 0/1 on rsp_data this cycle
- rsp_data  out  8*d  sb_out passed through combinationally
- rsp_inv  out  1  inverse flag of the returning byte
- busy  out  1  any tag valid in the pipeline

## Operation
- Issue condition: rnd_valid & ~flush & (req0_valid | req1_valid). No grant otherwise; pipeline still advances and inserts a bubble.
- Round-robin: register prio (reset 0) names the preferred requester. If both valid, grant prio. If one valid, grant it. After a grant to requester k, prio <= ~k.
- req*_ready is combinational from the valid/rnd_valid/flush/prio inputs. At most one ready per cycle. Requesters need not hold valid without ready, but must keep data stable while valid.
- sb_in / sb_inverse_in = granted requester's data / inv. Both are all-zero when nothing is granted, so no share is ever driven without an issue.
- Tag pipeline: LAT stages of {valid, owner, inv}. Stage 1 captures the issue. rsp*_valid, rsp_inv and sb_inverse_out come from stage LAT. sb_inverse_out = 0 when stage LAT is invalid.
- rsp0_valid = tag_valid[LAT] & owner==0. rsp1_valid = tag_valid[LAT] & owner==1. There is no response backpressure; owners must sink every response.
- rnd_use_k = issue delayed by Rk_DLY cycles, with R=0 combinational with issue. Strobes derive from the tag valid bits, so one issue yields exactly one pulse per bus.
- flush: on the next edge clear all tag valid bits and set prio <= 0. No grant occurs during the flush cycle. A response already at stage LAT in the flush cycle is still presented that cycle.
- busy = OR of all tag valid bits.

## Timing
- Reset (async assert, sync release): all tag stages invalid, prio=0. All outputs 0: ready, rsp valids, rnd_use, sb_inverse_*, sb_in, busy.
- Throughput: one issue per cycle. Latency: accepted at edge t, so rsp valid during the cycle after edge t+LAT-1, i.e. LAT cycles after acceptance.
- Back-to-back issues from alternating owners produce back-to-back responses in issue order. Order is never changed.
- Reset mid-operation discards all in-flight bytes with no response. rnd_use strobes for discarded issues are also suppressed.
- rnd_valid low for N cycles produces N bubbles and exactly N idle response cycles LAT later.

## Test plan
- Reset with both reqs valid and rnd_valid=1: all outputs 0 during reset. First grant goes to req0 one cycle after release, and rsp0_valid follows 6 cycles later carrying S(byte).
- Both requesters valid continuously, rnd_valid=1, 8 cycles: grants alternate 0,1,0,1… Responses alternate with matching owner. sbox(0x00)=0x63 and inverse(0x63)=0x00 are checked after unmasking.
- req0 inv=1 byte 0x63 then inv=0 byte 0x53: sb_inverse_in = 1,0 on the issue cycles and sb_inverse_out = 1,0 six cycles later. Results are 0x00 and 0xED.
- rnd_valid toggled 1,0,1: no ready while low. rnd_use_0/1/2 each pulse exactly twice, offset 0/2/4 cycles from the issues.
- Flush with 3 bytes in flight: none of them produce rsp*_valid after the flush edge, busy drops, and prio=0.
- rst_n asserted mid-stream, with 4 bytes in flight: all outputs drop asynchronously, and no stale response appears after release.
